// File: rtl/popcount22_unary_tx.sv
// Inverse popcount: each accepted count C becomes an N-bit serial frame with min(C,N) ones.
// Optional macro POPCOUNT22_SPREAD_EN spreads the ones evenly instead of thermometer order.
module popcount22_unary_tx #(
    parameter int N = 22,
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_count,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         out_bit,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         busy
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    // The count must be able to represent N itself.
    if ((1 << W) <= N) begin : g_width_check
        $error("popcount22_unary_tx: 2^W must exceed N");
    end

    typedef enum logic {IDLE, EMIT} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [IW-1:0] r_idx;
    logic [W-1:0]  r_cnt;
    logic [W-1:0]  w_sat;
    logic          w_bit;
    logic          w_at_last;
    logic          w_fire;

    assign w_sat     = (32'(in_count) > N) ? W'(N) : in_count;
    assign w_at_last = (r_idx == LAST);
    assign w_fire    = (r_state == EMIT) && out_ready;

`ifdef POPCOUNT22_SPREAD_EN
    logic [W:0] r_acc;
    logic [W:0] w_sum;

    assign w_sum = r_acc + {1'b0, r_cnt};
    assign w_bit = (w_sum >= (W+1)'(N));

    // Error accumulator: carries the fractional ones between bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (r_state == IDLE) begin
            if (in_valid) r_acc <= '0;
        end else if (out_ready) begin
            r_acc <= w_bit ? (w_sum - (W+1)'(N)) : w_sum;
        end
    end
`else
    assign w_bit = (32'(r_idx) < 32'(r_cnt));
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next state and handshake outputs.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = EMIT;
            end
            EMIT: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready && w_at_last) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Count latch and bit index; index wraps to 0 after the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (r_state == IDLE) begin
            if (in_valid) begin
                r_cnt <= w_sat;
                r_idx <= '0;
            end
        end else if (w_fire) begin
            r_idx <= w_at_last ? '0 : r_idx + IW'(1);
        end
    end

    assign out_bit  = (r_state == EMIT) && w_bit;
    assign out_last = (r_state == EMIT) && w_at_last;

endmodule

// File: tb/tb_popcount22_unary_tx.sv
// Self-checking bench for popcount22_unary_tx.
// Reference bit j of a frame is derived arithmetically from the saturated count.
module tb_popcount22_unary_tx;

    localparam int N = 22;
    localparam int W = 5;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] in_count;
    logic         in_valid;
    logic         in_ready;
    logic         out_bit;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic         busy;

    int checks = 0;
    int errors = 0;

    popcount22_unary_tx #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_count  (in_count),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_bit   (out_bit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int sat(input int c);
        return (c > N) ? N : c;
    endfunction

    function automatic int model_bit(input int c, input int j);
        int cc;
        cc = sat(c);
`ifdef POPCOUNT22_SPREAD_EN
        return ((j + 1) * cc) / N - (j * cc) / N;
`else
        return (j < cc) ? 1 : 0;
`endif
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, int'(in_ready), 1);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_out_bit"}, int'(out_bit), 0);
        chk({tag, "_out_last"}, int'(out_last), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    // Sends one count and collects a full frame; called right after a negedge.
    task automatic run_frame(input int c, input int stall_pct, input bit junk,
                             output logic [N-1:0] cap);
        int idx;
        int ones;
        int cyc;
        int waitc;
        bit prev_stall;
        logic prev_bit;
        logic prev_last;
        cap = '0;
        waitc = 0;
        while (!in_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        chk("idle_wait_timeout", int'(in_ready), 1);
        in_count  = W'(c);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = junk;
        chk("first_valid", int'(out_valid), 1);
        chk("busy_in_frame", int'(busy), 1);
        chk("in_ready_low", int'(in_ready), 0);
        idx = 0;
        ones = 0;
        cyc = 0;
        prev_stall = 1'b0;
        prev_bit = 1'b0;
        prev_last = 1'b0;
        while (idx < N && cyc < 2000) begin
            if (!out_valid) begin
                chk("valid_dropped", 0, 1);
                break;
            end
            if (prev_stall) begin
                chk("stall_bit_stable", int'(out_bit), int'(prev_bit));
                chk("stall_last_stable", int'(out_last), int'(prev_last));
            end
            chk($sformatf("bit%0d_c%0d", idx, c), int'(out_bit), model_bit(c, idx));
            chk($sformatf("last%0d", idx), int'(out_last), (idx == N - 1) ? 1 : 0);
            out_ready = ($urandom_range(99) >= stall_pct);
            prev_stall = !out_ready;
            prev_bit = out_bit;
            prev_last = out_last;
            if (out_ready) begin
                cap[idx] = out_bit;
                ones += int'(out_bit);
                idx++;
                if (idx == N) in_valid = 1'b0;
            end
            if (junk) in_count = W'($urandom);
            @(negedge clk);
            cyc++;
        end
        chk("frame_len", idx, N);
        chk("frame_ones", ones, sat(c));
        chk("in_ready_after", int'(in_ready), 1);
        chk("out_valid_after", int'(out_valid), 0);
        chk("busy_after", int'(busy), 0);
        out_ready = 1'b0;
        in_valid = 1'b0;
    endtask

    typedef struct {
        int count;
        int ones;
    } vec_t;

    initial begin
        vec_t vecs[7];
        logic [N-1:0] cap;
        logic [N-1:0] want;

        vecs[0] = '{7, 7};
        vecs[1] = '{0, 0};
        vecs[2] = '{22, 22};
        vecs[3] = '{31, 22};
        vecs[4] = '{11, 11};
        vecs[5] = '{1, 1};
        vecs[6] = '{21, 21};

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_count = '0;
        out_ready = 1'b0;
        #1;
        chk_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs("post_reset");

        for (int v = 0; v < 7; v++) begin
            run_frame(vecs[v].count, 0, 1'b0, cap);
            chk($sformatf("table_ones_c%0d", vecs[v].count),
                $countones(cap), vecs[v].ones);
`ifdef POPCOUNT22_SPREAD_EN
            want = 22'h2AAAAA;
            if (vecs[v].count == 11)
                chk("spread_c11_pattern", int'(cap), int'(want));
`else
            want = 22'h00007F;
            if (vecs[v].count == 7)
                chk("thermo_c7_pattern", int'(cap), int'(want));
`endif
        end

        run_frame(5, 40, 1'b0, cap);
        chk("stall_c5_ones", $countones(cap), 5);

        for (int r = 0; r < 15; r++) begin
            run_frame(int'($urandom_range(31)), int'($urandom_range(60)), 1'b0, cap);
        end

        run_frame(9, 20, 1'b1, cap);
        chk("ignore_in_valid_ones", $countones(cap), 9);

        // Abort a C=15 frame at bit 10.
        in_count = W'(15);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("pre_abort_busy", int'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("abort");
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs("abort_release");
        run_frame(3, 0, 1'b0, cap);
        chk("after_abort_c3_ones", $countones(cap), 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/popcount22_unary_tx.md
POPCOUNT22_UNARY_TX -- requirements
Module: popcount22_unary_tx

Interface
REQ-001 SHALL have parameter N, default 22, meaning the frame length in bits and the maximum count.
REQ-002 SHALL have parameter W, default 5, meaning the count width; the design SHALL require 2^W > N.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_count  input  W  requested number of ones in the frame.
REQ-006 SHALL have port in_valid  input  1  in_count is valid.
REQ-007 SHALL have port in_ready  output  1  block accepts in_count this cycle.
REQ-008 SHALL have port out_bit  output  1  current serial bit of the unary frame.
REQ-009 SHALL have port out_valid  output  1  out_bit is valid.
REQ-010 SHALL have port out_ready  input  1  downstream consumes out_bit this cycle.
REQ-011 SHALL have port out_last  output  1  high with the final bit (index N-1) of a frame.
REQ-012 SHALL have port busy  output  1  a frame is in progress.

Function
REQ-013 SHALL implement the inverse of a popcount: each accepted count C produces exactly N serial bits, of which exactly min(C,N) are 1.
REQ-014 SHALL saturate: in_count > N SHALL be latched as N.
REQ-015 SHALL use two states, IDLE and EMIT; in IDLE, in_ready=1, out_valid=0, busy=0; in EMIT, in_ready=0, out_valid=1, busy=1.
REQ-016 In IDLE, in_valid&&in_ready SHALL latch the saturated count, clear the bit index i to 0 and the accumulator to 0, and move to EMIT on the next edge.
REQ-017 In EMIT, out_bit/out_last SHALL be held stable while out_ready=0; i advances by 1 on each cycle with out_valid&&out_ready.
REQ-018 out_last SHALL equal (i==N-1) in EMIT and 0 otherwise.
REQ-019 A handshake at i==N-1 SHALL return to IDLE; the first out_valid of a frame SHALL appear on the cycle after input acceptance (one-cycle bubble between frames).
REQ-020 The index counter SHALL be ceil(log2 N) bits and SHALL never exceed N-1.
REQ-021 in_valid while in EMIT SHALL be ignored; in_count is sampled only at acceptance.

Reset
REQ-022 rst_n low SHALL asynchronously force IDLE, i=0, accumulator=0, latched count=0; outputs in_ready=1, out_valid=0, out_bit=0, out_last=0, busy=0.
REQ-023 Reset asserted mid-frame SHALL abort the frame; no partial frame resumes after reset release.

Configuration
REQ-024 Macro POPCOUNT22_SPREAD_EN SHALL select the bit ordering.
REQ-025 Without POPCOUNT22_SPREAD_EN: thermometer order, out_bit = (i < C).
REQ-026 With POPCOUNT22_SPREAD_EN: evenly spread order; per bit, s = acc + C, out_bit = (s >= N), acc updates to s-N if out_bit else s, only on a handshake; acc width W+1.
REQ-027 Both modes SHALL satisfy REQ-013 and identical handshake timing.

Verification
REQ-028 C=7, out_ready=1, no SPREAD: 22 bits = 1111111 followed by 15 zeros; out_last on bit 21; in_ready returns high the cycle after.
REQ-029 C=11 with SPREAD: bits 0,1,0,1,...; ones at odd indices; popcount 11.
REQ-030 C=0 -> 22 zeros; C=22 -> 22 ones; C=31 -> 22 ones (saturated), both modes.
REQ-031 Random out_ready stalls, C=5: out_bit/out_last stable during stalls; exactly 22 handshakes, 5 ones.
REQ-032 Pulse rst_n low at bit 10 of a C=15 frame -> outputs reach reset values immediately; new C=3 frame is then emitted correctly.
REQ-033 in_valid held high with changing in_count during EMIT -> no effect; only the count present at acceptance is emitted.
